// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares a dual-port RAM between instruction fetch (port 1),
//                and the load/store unit and debug loader (round-robin on
//                port 2). Blocks IFU reads that collide with a same-cycle
//                port-2 write, and sequences a debug memory halt
//                (RUN / DRAIN / HALTED).
//  Revision    : 1.0  initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch (read-only)
  input  logic              ifu_valid,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_ready,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  // load/store unit
  input  logic              lsu_valid,
  input  logic              lsu_rw,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_ready,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  // debug loader
  input  logic              dbg_valid,
  input  logic              dbg_rw,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rdata,
  // debug halt control
  input  logic              dbg_halt_req,
  output logic              dbg_halted,
  // RAM side
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr_1,
  output logic [DATA_W-1:0] ram_din_1,
  output logic              ram_rw_1,
  input  logic [DATA_W-1:0] ram_dout_1,
  output logic [ADDR_W-1:0] ram_addr_2,
  output logic [DATA_W-1:0] ram_din_2,
  output logic              ram_rw_2,
  input  logic [DATA_W-1:0] ram_dout_2
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t r_state;
  logic   r_dbg_halted;
  logic   r_last_p2_dbg;   // 1: DBG held port 2 last, 0: LSU did
  logic   r_ifu_rsp;
  logic   r_lsu_rsp;
  logic   r_dbg_rsp;

  logic              w_cpu_ok;
  logic              w_dbg_ok;
  logic              w_lsu_cand;
  logic              w_dbg_cand;
  logic              w_grant_lsu;
  logic              w_grant_dbg;
  logic              w_p2_grant;
  logic              w_p2_wr;
  logic [ADDR_W-1:0] w_p2_addr;
  logic [DATA_W-1:0] w_p2_wdata;
  logic              w_hazard;

  // Decide who may be granted this cycle; IFU loses to a colliding port-2 write
  always_comb begin
    // IFU/LSU only in a RUN cycle that is not starting a halt
    w_cpu_ok    = !rst && (r_state == ST_RUN) && !dbg_halt_req;
    // DBG is served in RUN and HALTED, never while draining
    w_dbg_ok    = !rst && (r_state != ST_DRAIN);
    w_lsu_cand  = lsu_valid && w_cpu_ok;
    w_dbg_cand  = dbg_valid && w_dbg_ok;
    // On a tie the requester that did not win last time gets the port
    w_grant_lsu = w_lsu_cand && (!w_dbg_cand || r_last_p2_dbg);
    w_grant_dbg = w_dbg_cand && !w_grant_lsu;
    w_p2_grant  = w_grant_lsu || w_grant_dbg;
    w_p2_wr     = w_grant_lsu ? lsu_rw : (w_grant_dbg && dbg_rw);
    w_p2_addr   = w_grant_dbg ? dbg_addr  : lsu_addr;
    w_p2_wdata  = w_grant_dbg ? dbg_wdata : lsu_wdata;
    w_hazard    = ifu_valid && w_p2_grant && w_p2_wr && (ifu_addr == w_p2_addr);
  end

  assign ifu_ready  = ifu_valid && w_cpu_ok && !w_hazard;
  assign lsu_ready  = w_grant_lsu;
  assign dbg_ready  = w_grant_dbg;
  assign ram_en     = ifu_ready || w_p2_grant;

  assign ram_addr_1 = ifu_addr;
  assign ram_din_1  = '0;
  assign ram_rw_1   = 1'b0;
  assign ram_addr_2 = w_p2_addr;
  assign ram_din_2  = w_p2_wdata;
  assign ram_rw_2   = w_p2_wr;

  assign ifu_rsp_valid = r_ifu_rsp;
  assign lsu_rsp_valid = r_lsu_rsp;
  assign dbg_rsp_valid = r_dbg_rsp;
  assign ifu_rdata     = ram_dout_1;
  assign lsu_rdata     = ram_dout_2;
  assign dbg_rdata     = ram_dout_2;
  assign dbg_halted    = r_dbg_halted;

  // Halt sequencer; dbg_halted is registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_dbg_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (dbg_halt_req) r_state <= ST_DRAIN;
          r_dbg_halted <= 1'b0;
        end
        ST_DRAIN: begin
          // one cycle lets any response in flight retire
          r_state      <= dbg_halt_req ? ST_HALTED : ST_RUN;
          r_dbg_halted <= dbg_halt_req;
        end
        ST_HALTED: begin
          r_state      <= dbg_halt_req ? ST_HALTED : ST_RUN;
          r_dbg_halted <= dbg_halt_req;
        end
        default: begin
          r_state      <= ST_RUN;
          r_dbg_halted <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle response pulses and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifu_rsp     <= 1'b0;
      r_lsu_rsp     <= 1'b0;
      r_dbg_rsp     <= 1'b0;
      r_last_p2_dbg <= 1'b1;
    end else begin
      r_ifu_rsp <= ifu_ready;
      r_lsu_rsp <= w_grant_lsu;
      r_dbg_rsp <= w_grant_dbg;
      if (w_p2_grant) r_last_p2_dbg <= w_grant_dbg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Directed self-checking bench for ram_port_arbiter with a
//                behavioural dual-port RAM attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ifu_valid = 1'b0;
  logic [7:0] ifu_addr  = '0;
  logic       ifu_ready, ifu_rsp_valid;
  logic [7:0] ifu_rdata;
  logic       lsu_valid = 1'b0, lsu_rw = 1'b0;
  logic [7:0] lsu_addr = '0, lsu_wdata = '0;
  logic       lsu_ready, lsu_rsp_valid;
  logic [7:0] lsu_rdata;
  logic       dbg_valid = 1'b0, dbg_rw = 1'b0;
  logic [7:0] dbg_addr = '0, dbg_wdata = '0;
  logic       dbg_ready, dbg_rsp_valid;
  logic [7:0] dbg_rdata;
  logic       dbg_halt_req = 1'b0;
  logic       dbg_halted;
  logic       ram_en;
  logic [7:0] ram_addr_1, ram_din_1, ram_addr_2, ram_din_2;
  logic       ram_rw_1, ram_rw_2;
  logic [7:0] ram_dout_1 = '0, ram_dout_2 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_valid(lsu_valid), .lsu_rw(lsu_rw), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ready(lsu_ready), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .dbg_valid(dbg_valid), .dbg_rw(dbg_rw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_rsp_valid(dbg_rsp_valid), .dbg_rdata(dbg_rdata),
    .dbg_halt_req(dbg_halt_req), .dbg_halted(dbg_halted),
    .ram_en(ram_en),
    .ram_addr_1(ram_addr_1), .ram_din_1(ram_din_1), .ram_rw_1(ram_rw_1), .ram_dout_1(ram_dout_1),
    .ram_addr_2(ram_addr_2), .ram_din_2(ram_din_2), .ram_rw_2(ram_rw_2), .ram_dout_2(ram_dout_2)
  );

  // Behavioural dual-port RAM: registered reads, outputs hold when disabled
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout_1 <= mem[ram_addr_1];
      if (ram_rw_2) mem[ram_addr_2] <= ram_din_2;
      else          ram_dout_2      <= mem[ram_addr_2];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_valid = 1'b0;
    lsu_valid = 1'b0;
    dbg_valid = 1'b0;
    lsu_rw    = 1'b0;
    dbg_rw    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;

    // ---------------- reset: readies held low even with requests ----------
    @(negedge clk);
    rst = 1'b1; ifu_valid = 1'b1; lsu_valid = 1'b1; dbg_valid = 1'b1;
    #1;
    chk("rst_ifu_ready", ifu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_dbg_ready", dbg_ready, 0);
    chk("rst_ram_en",    ram_en,    0);
    edge_wait();
    chk("rst_ifu_rsp", ifu_rsp_valid, 0);
    chk("rst_lsu_rsp", lsu_rsp_valid, 0);
    chk("rst_dbg_rsp", dbg_rsp_valid, 0);
    chk("rst_halted",  dbg_halted,    0);

    // ---------------- 1: IFU read 0x10 -------------------------------------
    @(negedge clk);
    rst = 1'b0; idle_inputs(); ifu_valid = 1'b1; ifu_addr = 8'h10;
    #1;
    chk("t1_ifu_ready", ifu_ready, 1);
    chk("t1_ram_en",    ram_en,    1);
    edge_wait();
    chk("t1_ifu_rsp",   ifu_rsp_valid, 1);
    chk("t1_ifu_rdata", ifu_rdata,     8'hA5);

    // ---------------- 2: LSU/DBG tie alternates, LSU first -----------------
    @(negedge clk);
    idle_inputs();
    lsu_valid = 1'b1; lsu_addr = 8'h10;
    dbg_valid = 1'b1; dbg_addr = 8'h11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_lsu_ready", lsu_ready, (k % 2 == 0) ? 1 : 0);
      chk("t2_dbg_ready", dbg_ready, (k % 2 == 1) ? 1 : 0);
      edge_wait();
      chk("t2_lsu_rsp", lsu_rsp_valid, (k % 2 == 0) ? 1 : 0);
      chk("t2_dbg_rsp", dbg_rsp_valid, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 0) chk("t2_lsu_rdata", lsu_rdata, 8'hA5);
      else            chk("t2_dbg_rdata", dbg_rdata, 8'h3C);
      @(negedge clk);
    end

    // ---------------- 3: write/read hazard on 0x20 --------------------------
    idle_inputs();
    lsu_valid = 1'b1; lsu_rw = 1'b1; lsu_addr = 8'h20; lsu_wdata = 8'h5C;
    ifu_valid = 1'b1; ifu_addr = 8'h20;
    #1;
    chk("t3_ifu_blocked", ifu_ready, 0);
    chk("t3_lsu_ready",   lsu_ready, 1);
    chk("t3_ram_rw_2",    ram_rw_2,  1);
    edge_wait();
    chk("t3_lsu_ack",  lsu_rsp_valid, 1);
    chk("t3_ifu_rsp0", ifu_rsp_valid, 0);
    @(negedge clk);
    lsu_valid = 1'b0; lsu_rw = 1'b0;
    #1;
    chk("t3_ifu_retry", ifu_ready, 1);
    edge_wait();
    chk("t3_ifu_rsp",   ifu_rsp_valid, 1);
    chk("t3_ifu_rdata", ifu_rdata,     8'h5C);

    // ---------------- 4: debug halt with LSU streaming ---------------------
    @(negedge clk);
    idle_inputs();
    lsu_valid = 1'b1; lsu_addr = 8'h20;
    #1;
    chk("t4_lsu_run", lsu_ready, 1);
    edge_wait();
    chk("t4_lsu_rsp_run", lsu_rsp_valid, 1);
    @(negedge clk);
    dbg_halt_req = 1'b1;                 // transition cycle
    #1;
    chk("t4_lsu_trans", lsu_ready, 0);
    chk("t4_en_trans",  ram_en,    0);
    edge_wait();
    chk("t4_halted_drain", dbg_halted,    0);
    chk("t4_lsu_rsp_tr",   lsu_rsp_valid, 0);
    @(negedge clk);                       // DRAIN
    dbg_valid = 1'b1; dbg_rw = 1'b1; dbg_addr = 8'h00; dbg_wdata = 8'hFF;
    #1;
    chk("t4_dbg_drain", dbg_ready, 0);
    chk("t4_lsu_drain", lsu_ready, 0);
    edge_wait();
    chk("t4_halted", dbg_halted, 1);
    @(negedge clk);                       // HALTED
    ifu_valid = 1'b1; ifu_addr = 8'h10;
    #1;
    chk("t4_dbg_halt_rdy", dbg_ready, 1);
    chk("t4_lsu_halt_rdy", lsu_ready, 0);
    chk("t4_ifu_halt_rdy", ifu_ready, 0);
    edge_wait();
    chk("t4_dbg_ack",     dbg_rsp_valid, 1);
    chk("t4_halted_hold", dbg_halted,    1);
    @(negedge clk);                       // release, still HALTED this cycle
    dbg_halt_req = 1'b0; dbg_valid = 1'b0; dbg_rw = 1'b0; ifu_valid = 1'b0;
    #1;
    chk("t4_lsu_rel", lsu_ready, 0);
    edge_wait();
    chk("t4_halted_rel", dbg_halted, 0);
    @(negedge clk);                       // RUN again: LSU reads back 0x00
    lsu_addr = 8'h00;
    #1;
    chk("t4_lsu_resume", lsu_ready, 1);
    edge_wait();
    chk("t4_lsu_rsp2",   lsu_rsp_valid, 1);
    chk("t4_dbg_wdata",  lsu_rdata,     8'hFF);

    // ---------------- 5: reset mid-transaction ------------------------------
    @(negedge clk);
    lsu_addr = 8'h11;                     // LSU wins -> last_p2 = LSU
    #1;
    chk("t5_lsu_acc", lsu_ready, 1);
    edge_wait();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_lsu_rdy_rst", lsu_ready, 0);
    edge_wait();
    chk("t5_lsu_rsp_rst", lsu_rsp_valid, 0);
    chk("t5_halted_rst",  dbg_halted,    0);
    @(negedge clk);
    rst = 1'b0; dbg_valid = 1'b1; dbg_addr = 8'h10;
    #1;
    chk("t5_tie_lsu", lsu_ready, 1);
    chk("t5_tie_dbg", dbg_ready, 0);
    edge_wait();

    // ---------------- 6: idle ----------------------------------------------
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_ram_en", ram_en, 0);
      edge_wait();
      chk("t6_rsp_all", {ifu_rsp_valid, lsu_rsp_valid, dbg_rsp_valid}, 3'b000);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
